// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encodings, default widths and
// the width of one {instr, pc} buffer entry.
package fetch_sequencer_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  function automatic int unsigned entry_w(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + data_w;
  endfunction

  localparam int unsigned ENTRY_W_DEF = entry_w(ADDR_W_DEF, DATA_W_DEF);

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding captured {instr, pc} entries; flush wins over push and pop.
module fetch_skid_buf
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = ENTRY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q, rd_q;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC/FSM, credit-limited ROM issue, redirect handling, and a
// two-entry output buffer presented to decode on a valid/ready handshake.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ROM_WORDS = 12,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_done
);

  localparam int unsigned ENTRY_W = entry_w(ADDR_W, DATA_W);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic [1:0]         count;
  logic [ENTRY_W-1:0] head;
  logic               pop, issue;
  logic [2:0]         occ;

  assign pop = if_valid && if_ready;

  // Occupancy the buffer will have once the word now in flight lands; one slot must remain.
  assign occ   = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == ST_RUN) && (32'(pc_q) < ROM_WORDS) && !br_valid &&
                 (32'(occ) < BUF_DEPTH);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (br_valid && (state_q != ST_IDLE)) begin
      pc_d    = br_target;
      state_d = (32'(br_target) >= ROM_WORDS) ? ST_HALT : ST_RUN;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        state_d = ST_RUN;
        pc_d    = ADDR_W'(RESET_PC);
      end
    end else if (issue) begin
      pc_d          = pc_q + 1'b1;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      if (32'(pc_q) == ROM_WORDS - 1) begin
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= ADDR_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_skid_buf #(
    .WIDTH(ENTRY_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data({rom_data, inflight_pc_q}),
    .pop      (pop),
    .flush    (br_valid),
    .count    (count),
    .head     (head)
  );

  assign rom_addr = pc_q;
  assign if_valid = (count != 2'd0);
  assign if_instr = if_valid ? head[ENTRY_W-1 -: DATA_W] : '0;
  assign if_pc    = if_valid ? head[ADDR_W-1:0] : '0;
  assign if_done  = (state_q == ST_HALT) && (count == 2'd0) && !inflight_q;

endmodule
